ppc_fetch_queue: RTL

PPC_FETCH_QUEUE -- requirements
Module: ppc_fetch_queue

---
 rtl/ppc_fetch_queue_pkg.sv | 17 +
 rtl/ppc_fetch_queue_if.sv | 25 ++
 rtl/ppc_fetch_queue_fifo.sv | 53 +++++
 rtl/ppc_fetch_queue.sv | 105 ++++++++++
 4 files changed

// File: rtl/ppc_fetch_queue_pkg.sv
// rtl/ppc_fetch_queue_pkg.sv - shared widths, FSM encoding and queue entry type
package ppc_defs;
  localparam int INST_W  = 32;
  localparam int DW_W    = 64;
  localparam int DADDR_W = 61;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [0:INST_W-1] inst;
    logic [0:DW_W-1]   pc;
  } fq_entry_t;
endpackage

// File: rtl/ppc_fetch_queue_if.sv
// rtl/ppc_fetch_queue_if.sv - fetch unit memory and consumer-side signal bundle
interface ppc_fetch_queue_if;
  import ppc_defs::*;

  logic                memReq;
  logic [0:DADDR_W-1]  memAddr;
  logic                memValid;
  logic [0:DW_W-1]     memData;
  logic                redirect;
  logic [0:DW_W-1]     redirectPC;
  logic                instValid;
  logic [0:INST_W-1]   inst;
  logic [0:DW_W-1]     instPC;
  logic                instReady;

  modport master (
    output memReq, memAddr, instValid, inst, instPC,
    input  memValid, memData, redirect, redirectPC, instReady
  );

  modport slave (
    input  memReq, memAddr, instValid, inst, instPC,
    output memValid, memData, redirect, redirectPC, instReady
  );
endinterface

// File: rtl/ppc_fetch_queue_fifo.sv
// rtl/ppc_fetch_queue_fifo.sv - two-write/one-read circular instruction buffer
module ppc_inst_fifo
  import ppc_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_wr0_en,
  input  fq_entry_t              i_wr0,
  input  logic                   i_wr1_en,
  input  fq_entry_t              i_wr1,
  input  logic                   i_rd_en,
  output logic                   o_valid,
  output fq_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);

  fq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_wr_ptr1;
  logic [PW:0]   r_count;
  logic [PW:0]   w_enq_n;
  logic [PW:0]   w_deq_n;

  assign w_wr_ptr1 = r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
  assign o_valid   = (r_count != '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_deq_n   = {{PW{1'b0}}, i_rd_en && o_valid};
  // Port 1 is only ever used together with port 0.
  assign w_enq_n   = {{PW{1'b0}}, i_wr0_en} + {{PW{1'b0}}, i_wr1_en};

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_enq_n[PW-1:0];
      r_rd_ptr <= r_rd_ptr + w_deq_n[PW-1:0];
      r_count  <= r_count + w_enq_n - w_deq_n;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr0_en) r_mem[r_wr_ptr]  <= i_wr0;
    if (i_wr1_en) r_mem[w_wr_ptr1] <= i_wr1;
  end
endmodule

// File: rtl/ppc_fetch_queue.sv
// rtl/ppc_fetch_queue.sv - doubleword instruction fetcher with redirect and small queue
module ppc_fetch_queue
  import ppc_defs::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               memReq,
  output logic [0:DADDR_W-1] memAddr,
  input  logic               memValid,
  input  logic [0:DW_W-1]    memData,
  input  logic               redirect,
  input  logic [0:DW_W-1]    redirectPC,
  output logic               instValid,
  output logic [0:INST_W-1]  inst,
  output logic [0:DW_W-1]    instPC,
  input  logic               instReady
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [0:DW_W-1] r_fetch_pc;
  logic [0:DW_W-1] w_fetch_pc_next;
  logic            w_take_resp;
  logic            w_odd;
  logic            w_free2;
  logic            w_deq;
  logic            w_fifo_valid;
  logic [CW-1:0]   w_count;
  fq_entry_t       w_wr0;
  fq_entry_t       w_wr1;
  fq_entry_t       w_head;

  assign w_free2 = (CW'(DEPTH) - w_count) >= CW'(2);
  assign w_odd   = r_fetch_pc[61];
  assign memAddr = r_fetch_pc[0:DADDR_W-1];

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    memReq          = 1'b0;
    w_take_resp     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!redirect && w_free2) begin
          memReq       = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          w_state_next = memValid ? IDLE : DROP;
        end else if (memValid) begin
          w_take_resp     = 1'b1;
          w_state_next    = IDLE;
          w_fetch_pc_next = {r_fetch_pc[0:DADDR_W-1] + 61'd1, 3'b000};
        end
      end
      DROP: begin
        if (memValid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (redirect) w_fetch_pc_next = redirectPC & ~64'd3;
    if (reset) memReq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  // An odd-word fetch address skips the low word of the doubleword.
  assign w_wr0.inst = w_odd ? memData[32:63] : memData[0:31];
  assign w_wr0.pc   = r_fetch_pc;
  assign w_wr1.inst = memData[32:63];
  assign w_wr1.pc   = r_fetch_pc + 64'd4;
  assign w_deq      = instValid && instReady && !redirect;

  ppc_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (redirect),
    .i_wr0_en (w_take_resp && !reset),
    .i_wr0    (w_wr0),
    .i_wr1_en (w_take_resp && !reset && !w_odd),
    .i_wr1    (w_wr1),
    .i_rd_en  (w_deq),
    .o_valid  (w_fifo_valid),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  assign instValid = w_fifo_valid && !reset;
  assign inst      = instValid ? w_head.inst : '0;
  assign instPC    = instValid ? w_head.pc   : '0;
endmodule
